// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory request bridge.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } mem_state_t;

  // Widest strobe vector the helpers accept (1024-bit words).
  localparam int unsigned STRB_MAX = 128;

  // Number of byte-offset bits below the word index for a given word width.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    int unsigned lsb;
    lsb = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < (data_width / 8)) lsb = i + 1;
    end
    return lsb;
  endfunction

  // True when every one of the low nbytes strobe bits is set.
  function automatic logic strb_full(input logic [STRB_MAX-1:0] wstrb,
                                     input int unsigned        nbytes);
    logic full;
    full = 1'b1;
    for (int unsigned i = 0; i < STRB_MAX; i++) begin
      if ((i < nbytes) && !wstrb[i]) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge: strobed lanes take the new word, the rest keep the old word.
module byte_merge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged_c
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  always_comb begin
    merged_c = old_word;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (strb[k]) merged_c[8*k +: 8] = new_word[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_rmw_bridge.sv
// Byte-addressed load/store front end for the word-wide memory; partial
// stores are serviced as read-modify-write. One request in flight.
module mem_rmw_bridge
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_SIZE  = 1024
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_enable,
  output logic                    mem_write,
  input  logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);

  mem_state_t            state_q, state_nxt;
  logic                  is_store_q, is_store_nxt;
  logic [DATA_WIDTH-1:0] idx_q, idx_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [STRB_W-1:0]     wstrb_q, wstrb_nxt;

  logic                  req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                  mem_enable_nxt, mem_write_nxt;
  logic [DATA_WIDTH-1:0] mem_addr_nxt, mem_wdata_nxt;

  logic [DATA_WIDTH-1:0] req_index;
  logic [DATA_WIDTH-1:0] merged_c;
  logic                  req_strb_full;

  assign req_index     = req_addr >> ADDR_LSB;
  assign req_strb_full = strb_full(STRB_MAX'(req_wstrb), STRB_W);

  // Byte offset bits are deliberately ignored; lane selection is by strobe.
  generate
    if (ADDR_LSB > 0) begin : g_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^req_addr[ADDR_LSB-1:0];
    end
  endgenerate

  byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_byte_merge (
    .old_word (mem_rdata),
    .new_word (wdata_q),
    .strb     (wstrb_q),
    .merged_c (merged_c)
  );

  // State, latched request and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_nxt;
      is_store_q <= is_store_nxt;
      idx_q      <= idx_nxt;
      wdata_q    <= wdata_nxt;
      wstrb_q    <= wstrb_nxt;
      req_ready  <= req_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      mem_enable <= mem_enable_nxt;
      mem_write  <= mem_write_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  // Next state, then outputs decoded from the state being entered.
  always_comb begin
    state_nxt     = state_q;
    is_store_nxt  = is_store_q;
    idx_nxt       = idx_q;
    wdata_nxt     = wdata_q;
    wstrb_nxt     = wstrb_q;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;

    unique case (state_q)
      ST_IDLE: begin
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
        if (req_valid && req_ready) begin
          is_store_nxt = req_write;
          idx_nxt      = req_index;
          wdata_nxt    = req_wdata;
          wstrb_nxt    = req_wstrb;
          if (req_index >= DATA_WIDTH'(DATA_SIZE)) begin
            state_nxt   = ST_RESP;
            rsp_err_nxt = 1'b1;
          end else if (req_write && (req_wstrb == '0)) begin
            state_nxt = ST_RESP;
          end else if (req_write && req_strb_full) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (mem_ready == 1'b1) begin
          if (is_store_q) begin
            state_nxt = ST_WRITE;
            wdata_nxt = merged_c;
          end else begin
            state_nxt     = ST_RESP;
            rsp_rdata_nxt = mem_rdata;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ready == 1'b1) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt     = ST_IDLE;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    req_ready_nxt  = (state_nxt == ST_IDLE);
    rsp_valid_nxt  = (state_nxt == ST_RESP);
    mem_enable_nxt = (state_nxt == ST_READ) || (state_nxt == ST_WRITE);
    mem_write_nxt  = (state_nxt == ST_WRITE);
    mem_addr_nxt   = mem_enable_nxt ? idx_nxt : '0;
    mem_wdata_nxt  = mem_write_nxt ? wdata_nxt : '0;
  end

endmodule

// File: tb/tb_mem_rmw_bridge.sv
// Self-checking bench for mem_rmw_bridge with a behavioural memory and a
// word-array reference model of load/store semantics.
module tb_mem_rmw_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned DS = 1024;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = $clog2(DS);

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          req_valid, req_ready, req_write;
  logic [DW-1:0] req_addr, req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_enable, mem_write, mem_ready;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk_in = ~clk_in;

  mem_rmw_bridge #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural memory: asynchronous read, write on the edge, optional stalls.
  logic [DW-1:0] mem_arr [DS];
  logic [DW-1:0] ref_mem [DS];
  logic [IW-1:0] mem_idx;
  logic          stall = 1'b0, stall_en = 1'b0;
  logic          bd_we = 1'b0;
  logic [IW-1:0] bd_idx = '0;
  logic [DW-1:0] bd_data = '0;

  assign mem_idx   = IW'(mem_addr % DW'(DS));
  assign mem_ready = mem_enable & ~stall;
  assign mem_rdata = (mem_enable && !mem_write) ? mem_arr[mem_idx] : '0;

  always @(posedge clk_in) begin
    if (bd_we) mem_arr[bd_idx] <= bd_data;
    else if (mem_enable && mem_write && mem_ready) mem_arr[mem_idx] <= mem_wdata;
  end

  always @(negedge clk_in) stall = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;

  // Activity monitors.
  int            n_cmp = 0, n_fail = 0;
  int            en_cnt = 0, wr_cnt = 0, rsp_cnt = 0, cyc = 0;
  logic [DW-1:0] rd_addr_seen = '0, wr_addr_seen = '0, wr_data_seen = '0;
  int            acc_q[$];

  always @(negedge clk_in) begin
    if (mem_enable) begin
      en_cnt++;
      if (mem_write) begin
        wr_cnt++;
        wr_addr_seen = mem_addr;
        wr_data_seen = mem_wdata;
      end else begin
        rd_addr_seen = mem_addr;
      end
    end
  end

  always @(posedge clk_in) begin
    cyc++;
    if (rst_n_in && req_valid && req_ready) acc_q.push_back(cyc);
    if (rst_n_in && rsp_valid && rsp_ready) rsp_cnt++;
  end

  // Reference model: word array, byte-granular stores, range check on index.
  function automatic void ref_access(input logic w, input logic [DW-1:0] a,
                                     input logic [DW-1:0] d, input logic [SW-1:0] s,
                                     output logic [DW-1:0] rd, output logic er);
    int unsigned idx;
    idx = a / SW;
    rd  = '0;
    er  = 1'b0;
    if (idx >= DS) begin
      er = 1'b1;
      return;
    end
    if (!w) rd = ref_mem[idx];
    else for (int k = 0; k < int'(SW); k++) if (s[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
  endfunction

  task automatic backdoor(input int idx, input logic [DW-1:0] v);
    @(negedge clk_in);
    bd_we = 1'b1; bd_idx = IW'(idx); bd_data = v;
    @(negedge clk_in);
    bd_we = 1'b0;
    ref_mem[idx] = v;
  endtask

  // One request/response; caller is at a negedge with the bridge idle.
  task automatic do_req(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output logic [DW-1:0] rd,
                        output logic er, output int lat, output bit to);
    int n;
    to = 1'b0; rd = '0; er = 1'b0; lat = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk_in); n++; end
    if (req_ready !== 1'b1) begin to = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk_in); lat++; end
    if (rsp_valid !== 1'b1) begin to = 1'b1; return; end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++; if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin n_fail++;
      $display("FAIL reset_flags: got rdy/vld/err=%b want 100", {req_ready, rsp_valid, rsp_err}); end
    n_cmp++; if (rsp_rdata !== '0) begin n_fail++;
      $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if ({mem_enable, mem_write} !== 2'b00 || mem_addr !== '0 || mem_wdata !== '0) begin n_fail++;
      $display("FAIL reset_mem: got en=%b wr=%b addr=%h wdata=%h want all 0", mem_enable, mem_write, mem_addr, mem_wdata); end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++;
      $display("FAIL post_reset_idle: got rdy/vld=%b want 10", {req_ready, rsp_valid}); end
    for (int i = 0; i < 64; i++) backdoor(i, DW'($urandom));
  endtask

  task automatic test_load();
    logic [DW-1:0] rd; logic er; int lat; bit to;
    backdoor(4, 32'hDEADBEEF);
    en_cnt = 0;
    do_req(1'b0, 32'h10, '0, '0, rd, er, lat, to);
    n_cmp++; if (to || rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++;
      $display("FAIL load_data: got rd=%h err=%b to=%b want DEADBEEF 0", rd, er, to); end
    n_cmp++; if (lat !== 2 || en_cnt !== 1 || rd_addr_seen !== 32'd4) begin n_fail++;
      $display("FAIL load_timing: got lat=%0d en=%0d addr=%0d want 2 1 4", lat, en_cnt, rd_addr_seen); end
  endtask

  task automatic test_full_store();
    logic [DW-1:0] rd, erd; logic er, eer; int lat; bit to;
    ref_access(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, erd, eer);
    en_cnt = 0; wr_cnt = 0;
    do_req(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, rd, er, lat, to);
    n_cmp++; if (to || lat !== 2 || en_cnt !== 1 || wr_cnt !== 1 || wr_addr_seen !== 32'd8) begin n_fail++;
      $display("FAIL full_store: got to=%b lat=%0d en=%0d wr=%0d addr=%0d want 0 2 1 1 8", to, lat, en_cnt, wr_cnt, wr_addr_seen); end
    n_cmp++; if (rd !== '0 || er !== 1'b0) begin n_fail++;
      $display("FAIL full_store_rsp: got rd=%h err=%b want 0 0", rd, er); end
    do_req(1'b0, 32'h20, '0, '0, rd, er, lat, to);
    n_cmp++; if (to || rd !== 32'hA5A5A5A5) begin n_fail++;
      $display("FAIL full_store_readback: got %h want A5A5A5A5", rd); end
  endtask

  task automatic test_partial_store();
    logic [DW-1:0] rd, erd; logic er, eer; int lat; bit to;
    ref_access(1'b1, 32'h10, 32'h000000FF, 4'h1, erd, eer);
    en_cnt = 0; wr_cnt = 0;
    do_req(1'b1, 32'h10, 32'h000000FF, 4'h1, rd, er, lat, to);
    n_cmp++; if (to || lat !== 3 || en_cnt !== 2 || wr_cnt !== 1) begin n_fail++;
      $display("FAIL partial_timing: got to=%b lat=%0d en=%0d wr=%0d want 0 3 2 1", to, lat, en_cnt, wr_cnt); end
    n_cmp++; if (wr_data_seen !== 32'hDEADBEFF || wr_addr_seen !== 32'd4) begin n_fail++;
      $display("FAIL partial_wdata: got %h @%0d want DEADBEFF @4", wr_data_seen, wr_addr_seen); end
    do_req(1'b0, 32'h13, '0, '0, rd, er, lat, to);
    n_cmp++; if (to || rd !== 32'hDEADBEFF) begin n_fail++;
      $display("FAIL partial_readback: got %h want DEADBEFF", rd); end
  endtask

  task automatic test_error_and_zero_strobe();
    logic [DW-1:0] rd; logic er; int lat; bit to;
    en_cnt = 0;
    do_req(1'b0, 32'h1000, '0, '0, rd, er, lat, to);
    n_cmp++; if (to || er !== 1'b1 || rd !== '0 || lat !== 1 || en_cnt !== 0) begin n_fail++;
      $display("FAIL oob_load: got err=%b rd=%h lat=%0d en=%0d want 1 0 1 0", er, rd, lat, en_cnt); end
    do_req(1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'hF, rd, er, lat, to);
    n_cmp++; if (to || er !== 1'b1 || lat !== 1 || en_cnt !== 0) begin n_fail++;
      $display("FAIL oob_store: got err=%b lat=%0d en=%0d want 1 1 0", er, lat, en_cnt); end
    do_req(1'b1, 32'h40, 32'hCAFEF00D, 4'h0, rd, er, lat, to);
    n_cmp++; if (to || er !== 1'b0 || rd !== '0 || lat !== 1 || en_cnt !== 0) begin n_fail++;
      $display("FAIL zero_strobe: got err=%b rd=%h lat=%0d en=%0d want 0 0 1 0", er, rd, lat, en_cnt); end
  endtask

  task automatic test_backpressure();
    int n, c0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
    @(posedge clk_in); @(negedge clk_in);
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk_in); n++; end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++;
      $display("FAIL hold_rsp_arrives: got rsp_valid=%b want 1", rsp_valid); end
    c0 = rsp_cnt;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5A5A5 || req_ready !== 1'b0) begin n_fail++;
        $display("FAIL hold_stable[%0d]: got vld=%b rd=%h rdy=%b want 1 A5A5A5A5 0", k, rsp_valid, rsp_rdata, req_ready); end
      @(negedge clk_in);
    end
    rsp_ready = 1'b1;
    repeat (5) @(negedge clk_in);
    n_cmp++; if (rsp_cnt - c0 !== 1 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL hold_one_rsp: got %0d responses vld=%b want 1 0", rsp_cnt - c0, rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; logic er; int lat; bit to;
    acc_q.delete();
    do_req(1'b0, 32'h20, '0, '0, rd, er, lat, to);
    do_req(1'b0, 32'h10, '0, '0, rd, er, lat, to);
    n_cmp++; if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != 3) begin n_fail++;
      $display("FAIL b2b_period: got %0d accepts, period %0d want 2 3", acc_q.size(),
               (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1); end
    n_cmp++; if (to || rd !== 32'hDEADBEFF) begin n_fail++;
      $display("FAIL b2b_data: got %h want DEADBEFF", rd); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd, erd; logic er, eer; int lat; bit to;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_wstrb = 4'b0110;
    @(posedge clk_in); @(negedge clk_in);
    req_valid = 1'b0;
    n_cmp++; if ({mem_enable, mem_write} !== 2'b10 || mem_addr !== 32'd12) begin n_fail++;
      $display("FAIL rmw_read_phase: got en=%b wr=%b addr=%0d want 1 0 12", mem_enable, mem_write, mem_addr); end
    rst_n_in = 1'b0;
    #1;
    n_cmp++; if ({req_ready, rsp_valid, rsp_err, mem_enable, mem_write} !== 5'b10000 ||
                 mem_addr !== '0 || mem_wdata !== '0 || rsp_rdata !== '0) begin n_fail++;
      $display("FAIL mid_reset_outputs: got rdy=%b vld=%b en=%b wr=%b addr=%h want 1 0 0 0 0",
               req_ready, rsp_valid, mem_enable, mem_write, mem_addr); end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    ref_access(1'b0, 32'h30, '0, '0, erd, eer);
    do_req(1'b0, 32'h30, '0, '0, rd, er, lat, to);
    n_cmp++; if (to || rd !== erd || lat !== 2) begin n_fail++;
      $display("FAIL mid_reset_mem: got %h lat=%0d want %h 2", rd, lat, erd); end
  endtask

  task automatic test_random();
    logic [DW-1:0] a, d, rd, erd; logic [SW-1:0] s; logic w, er, eer; int lat; bit to;
    stall_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom);
      s = SW'($urandom);
      d = DW'($urandom);
      if ($urandom_range(0, 7) == 0) a = DW'($urandom) | 32'h1000;
      else a = (DW'($urandom_range(0, 63)) << 2) | DW'($urandom_range(0, 3));
      ref_access(w, a, d, s, erd, eer);
      do_req(w, a, d, s, rd, er, lat, to);
      n_cmp++; if (to || rd !== erd || er !== eer) begin n_fail++;
        $display("FAIL rand[%0d] w=%b a=%h s=%b: got rd=%h err=%b to=%b want %h %b", i, w, a, s, rd, er, to, erd, eer); end
    end
    stall_en = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_load();
    test_full_store();
    test_partial_store();
    test_error_and_zero_strobe();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
